// File: rtl/game_flow_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : game_flow_ctrl_if                                             |
// | Brief    : Input pulses and game-state outputs of the flow sequencer.    |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
interface game_flow_ctrl_if #(
  parameter int NUM_SKILLS = 3
);
  logic                  start_press;
  logic                  pause_press;
  logic                  ball_lost;
  logic                  bricks_clear;
  logic [NUM_SKILLS-1:0] skill_req;
  logic [2:0]            state;
  logic [3:0]            stage_idx;
  logic                  load_stage;
  logic [3:0]            lives;
  logic [2:0]            skill_pts;
  logic [NUM_SKILLS-1:0] skill_active;
  logic [NUM_SKILLS-1:0] skill_grant;

  // master drives the input pulses, slave is the sequencer itself
  modport master (
    output start_press, pause_press, ball_lost, bricks_clear, skill_req,
    input  state, stage_idx, load_stage, lives, skill_pts, skill_active, skill_grant
  );

  modport slave (
    input  start_press, pause_press, ball_lost, bricks_clear, skill_req,
    output state, stage_idx, load_stage, lives, skill_pts, skill_active, skill_grant
  );
endinterface
`default_nettype wire

// File: rtl/game_flow_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : game_flow_ctrl                                                |
// | Brief    : N-stage breakout game-flow sequencer with lives and skills.   |
// |            Optional GAMEFLOW_BONUS_LIFE_EN: +1 life per stage clear.     |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module game_flow_ctrl #(
  parameter int NUM_STAGES   = 3,
  parameter int LIVES        = 5,
  parameter int SKILL_POINTS = 3,
  parameter int NUM_SKILLS   = 3,
  parameter int SKILL_TICKS  = 100,
  parameter int CLEAR_HOLD   = 40
) (
  input  logic                 clk,
  input  logic                 rst,
  game_flow_ctrl_if.slave      bus
);

  typedef enum logic [2:0] {
    S_MENU  = 3'd0,
    S_PLAY  = 3'd1,
    S_PAUSE = 3'd2,
    S_CLEAR = 3'd3,
    S_WIN   = 3'd4,
    S_LOSE  = 3'd5
  } state_t;

  localparam int             c_TW        = $clog2(SKILL_TICKS + 1);
  localparam int             c_HW        = $clog2(CLEAR_HOLD + 1);
  localparam logic [3:0]     c_LAST      = 4'(NUM_STAGES - 1);
  localparam logic [3:0]     c_LIVES     = 4'(LIVES);
  localparam logic [2:0]     c_PTS       = 3'(SKILL_POINTS);
  localparam logic [c_TW-1:0] c_TICKS    = c_TW'(SKILL_TICKS);
  localparam logic [c_HW-1:0] c_HOLD_LD  = c_HW'(CLEAR_HOLD - 1);

  state_t                r_state,       w_state;
  logic [3:0]            r_stage_idx,   w_stage_idx;
  logic                  r_load_stage,  w_load_stage;
  logic [3:0]            r_lives,       w_lives;
  logic [2:0]            r_skill_pts,   w_skill_pts;
  logic [NUM_SKILLS-1:0] r_skill_grant, w_skill_grant;
  logic [NUM_SKILLS-1:0] r_skill_active, w_skill_active;
  logic [c_TW-1:0]       r_timer [NUM_SKILLS];
  logic [c_TW-1:0]       w_timer [NUM_SKILLS];
  logic [c_HW-1:0]       r_hold,        w_hold;
  logic                  w_clear_timers;
  logic                  w_found;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= S_MENU;
      r_stage_idx    <= '0;
      r_load_stage   <= 1'b0;
      r_lives        <= c_LIVES;
      r_skill_pts    <= c_PTS;
      r_skill_grant  <= '0;
      r_skill_active <= '0;
      r_hold         <= '0;
      for (int i = 0; i < NUM_SKILLS; i++) r_timer[i] <= '0;
    end else begin
      r_state        <= w_state;
      r_stage_idx    <= w_stage_idx;
      r_load_stage   <= w_load_stage;
      r_lives        <= w_lives;
      r_skill_pts    <= w_skill_pts;
      r_skill_grant  <= w_skill_grant;
      r_skill_active <= w_skill_active;
      r_hold         <= w_hold;
      for (int i = 0; i < NUM_SKILLS; i++) r_timer[i] <= w_timer[i];
    end
  end

  always_comb begin
    w_state        = r_state;
    w_stage_idx    = r_stage_idx;
    w_load_stage   = 1'b0;
    w_lives        = r_lives;
    w_skill_pts    = r_skill_pts;
    w_skill_grant  = '0;
    w_hold         = r_hold;
    w_clear_timers = 1'b0;
    w_found        = 1'b0;
    w_timer        = r_timer;

    case (r_state)
      S_MENU: begin
        if (bus.start_press) begin
          w_state        = S_PLAY;
          w_stage_idx    = '0;
          w_load_stage   = 1'b1;
          w_lives        = c_LIVES;
          w_skill_pts    = c_PTS;
          w_clear_timers = 1'b1;
        end
      end
      S_PLAY: begin
        for (int i = 0; i < NUM_SKILLS; i++)
          if (r_timer[i] != '0) w_timer[i] = r_timer[i] - 1'b1;
        // Leaving play for clear/win/lose drops every running skill.
        if (bus.bricks_clear) begin
          w_clear_timers = 1'b1;
          if (r_stage_idx == c_LAST) begin
            w_state = S_WIN;
          end else begin
            w_state = S_CLEAR;
            w_hold  = c_HOLD_LD;
`ifdef GAMEFLOW_BONUS_LIFE_EN
            if (r_lives != 4'd15) w_lives = r_lives + 4'd1;
`endif
          end
        end else if (bus.ball_lost && r_lives <= 4'd1) begin
          w_lives        = '0;
          w_state        = S_LOSE;
          w_clear_timers = 1'b1;
        end else begin
          if (bus.ball_lost)        w_lives = r_lives - 4'd1;
          else if (bus.pause_press) w_state = S_PAUSE;
          // Lowest-index eligible request wins; the rest are dropped.
          if (r_skill_pts != '0) begin
            for (int i = 0; i < NUM_SKILLS; i++) begin
              if (!w_found && bus.skill_req[i] && !r_skill_active[i]) begin
                w_found          = 1'b1;
                w_skill_grant[i] = 1'b1;
                w_timer[i]       = c_TICKS;
                w_skill_pts      = r_skill_pts - 3'd1;
              end
            end
          end
        end
      end
      S_PAUSE: begin
        if (bus.pause_press) w_state = S_PLAY;
      end
      S_CLEAR: begin
        if (r_hold == '0) begin
          w_state      = S_PLAY;
          w_stage_idx  = r_stage_idx + 4'd1;
          w_load_stage = 1'b1;
        end else begin
          w_hold = r_hold - 1'b1;
        end
      end
      S_WIN, S_LOSE: begin
        if (bus.start_press) begin
          w_state     = S_MENU;
          w_stage_idx = '0;
        end
      end
      default: w_state = S_MENU;
    endcase

    if (w_clear_timers)
      for (int i = 0; i < NUM_SKILLS; i++) w_timer[i] = '0;
  end

  genvar g;
  generate
    for (g = 0; g < NUM_SKILLS; g++) begin : g_skill_active
      assign w_skill_active[g] = (w_timer[g] != '0);
    end
  endgenerate

  assign bus.state        = r_state;
  assign bus.stage_idx    = r_stage_idx;
  assign bus.load_stage   = r_load_stage;
  assign bus.lives        = r_lives;
  assign bus.skill_pts    = r_skill_pts;
  assign bus.skill_active = r_skill_active;
  assign bus.skill_grant  = r_skill_grant;

endmodule
`default_nettype wire

// File: doc/game_flow_ctrl.md
Name: game_flow_ctrl

Overview:
- Parametrised game-flow sequencer for the breakout design: generalises the fixed MENU/STAGE1/WIN/LOSE controller to N stages, configurable lives, skill points and skill-duration timers.
- Sits between the input pulses (start, pause, keyboard skill requests) and the ball/brick engine.
- Drives stage-load strobes, the game state, life and skill counters, and per-skill active flags consumed by ball control, VGA address generation, music and LEDs.
- All logic runs on the game tick clock.

Parameters:
- NUM_STAGES, 3, number of playable stages (1..16).
- LIVES, 5, lives loaded at game start (1..15).
- SKILL_POINTS, 3, skill points loaded at game start (0..7); not refilled between stages.
- NUM_SKILLS, 3, number of independent skills (1..8).
- SKILL_TICKS, 100, ticks a skill stays active once granted (>=1).
- CLEAR_HOLD, 40, ticks spent in STAGE_CLEAR before the next stage loads (>=1).

Ports:
- clk  in  1  game tick clock
- rst  in  1  asynchronous, active-high reset
- start_press  in  1  one-cycle pulse, debounced start button
- pause_press  in  1  one-cycle pulse, toggles pause
- ball_lost  in  1  one-cycle pulse, ball fell below the paddle
- bricks_clear  in  1  level, current brick map is empty
- skill_req  in  NUM_SKILLS  one-cycle request pulses, bit i = skill i
- state  out  3  0 MENU, 1 PLAY, 2 PAUSE, 3 STAGE_CLEAR, 4 WIN, 5 LOSE
- stage_idx  out  4  current stage, 0-based
- load_stage  out  1  one-cycle strobe: engine reloads bricks/ball for stage_idx
- lives  out  4  remaining lives
- skill_pts  out  3  remaining skill points
- skill_active  out  NUM_SKILLS  bit i high while skill i is running
- skill_grant  out  NUM_SKILLS  one-cycle pulse when a request is accepted

Behaviour:
- Reset values: state=MENU, stage_idx=0, load_stage=0, lives=LIVES, skill_pts=SKILL_POINTS, skill_active=0, skill_grant=0, all timers 0. Reset mid-game aborts immediately with no pending strobe.
- MENU
  - start_press -> PLAY next cycle; load_stage=1 in that same registered cycle, stage_idx=0.
  - lives and skill_pts are reloaded on this transition.
- PLAY, priority order (highest first):
  - bricks_clear -> STAGE_CLEAR, or WIN if stage_idx==NUM_STAGES-1.
  - ball_lost: if lives==1, lives=0 and go to LOSE; otherwise lives-1 and stay in PLAY.
  - pause_press -> PAUSE.
  - A simultaneous bricks_clear and ball_lost counts as a clear; the life is not lost.
- PAUSE
  - pause_press -> PLAY.
  - ball_lost, bricks_clear and skill_req are ignored.
  - Skill timers freeze.
- STAGE_CLEAR
  - Hold counter runs from CLEAR_HOLD-1 down to 0.
  - At 0: stage_idx+1, state=PLAY, load_stage pulse.
  - All skill_active flags and timers clear on entry.
- WIN, LOSE
  - Terminal states. start_press -> MENU with stage_idx=0; counters are reloaded on the next start.
- Skills (PLAY only)
  - Request i is accepted when skill_pts>0 and skill_active[i]==0.
  - If several bits are requested in one cycle, only the lowest eligible index is granted.
  - On acceptance: skill_pts-1, skill_grant[i] pulses, timer i loads SKILL_TICKS.
  - skill_active[i] = (timer_i != 0); timer decrements once per PLAY cycle.
  - Duration is exactly SKILL_TICKS cycles after the grant cycle.
  - Requests while skill_pts==0 are dropped silently.
- Latency: all outputs are registered, one cycle after the causing input.
- Counters saturate: lives and skill_pts never wrap below 0.

Optional Feature:
- Macro: GAMEFLOW_BONUS_LIFE_EN.
- Defined: entering STAGE_CLEAR adds one life, saturating at 15; entering WIN does not.
- Undefined: lives are unchanged across stage transitions.

Test Plan:
- Reset, then start_press:
  - Next cycle state=1, stage_idx=0, load_stage=1 for exactly one cycle, lives=5, skill_pts=3.
- PLAY with lives=1, ball_lost pulse:
  - lives=0 and state=5 next cycle.
  - start_press then gives state=0.
- PLAY on stage 0, bricks_clear high:
  - state=3.
  - After 40 cycles, stage_idx=1, state=1, load_stage pulses once.
  - With the macro defined, lives goes 5->6.
- skill_req=3'b011 with skill_pts=3:
  - Only skill_grant=3'b001; skill_pts=2; skill_active[0] high for 100 cycles.
  - A re-request of skill 0 during that window is rejected.
- Pause during an active skill at timer=50:
  - pause_press, wait 30 cycles, pause_press.
  - skill_active stays high for a further 50 PLAY cycles; ball_lost during the pause leaves lives unchanged.
- On the last stage (stage_idx=2), bricks_clear and ball_lost in the same cycle:
  - state=4 (WIN), lives unchanged.
